// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES decrypt round datapath.
package aes_dec_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_COL_W   = 32;
    localparam int unsigned AES_NCOL    = AES_STATE_W / AES_COL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } imix_state_e;

    // Column 0 lives in the most significant word of the state.
    function automatic logic [AES_COL_W-1:0] col_sel(input logic [AES_STATE_W-1:0] state,
                                                     input logic [1:0]             idx);
        return state[AES_STATE_W - 1 - AES_COL_W * 32'(idx) -: AES_COL_W];
    endfunction

endpackage

// File: rtl/imix_single_col.sv
// Combinational InvMixColumns of one 32-bit column over GF(2^8), x^8+x^4+x^3+x+1.
module imix_single_col
    import aes_dec_pkg::*;
(
    input  logic [AES_COL_W-1:0] i_col,
    output logic [AES_COL_W-1:0] o_col
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_a   [4];
    logic [7:0] w_x2  [4];
    logic [7:0] w_x4  [4];
    logic [7:0] w_x8  [4];
    logic [7:0] w_m9  [4];
    logic [7:0] w_m11 [4];
    logic [7:0] w_m13 [4];
    logic [7:0] w_m14 [4];

    // Multiples 9, 11, 13, 14 built from repeated doubling.
    always_comb begin
        for (int unsigned r = 0; r < 4; r++) begin
            w_a[r]   = i_col[AES_COL_W - 1 - 8 * r -: 8];
            w_x2[r]  = xt(w_a[r]);
            w_x4[r]  = xt(w_x2[r]);
            w_x8[r]  = xt(w_x4[r]);
            w_m9[r]  = w_x8[r] ^ w_a[r];
            w_m11[r] = w_x8[r] ^ w_x2[r] ^ w_a[r];
            w_m13[r] = w_x8[r] ^ w_x4[r] ^ w_a[r];
            w_m14[r] = w_x8[r] ^ w_x4[r] ^ w_x2[r];
        end
    end

    assign o_col = {w_m14[0] ^ w_m11[1] ^ w_m13[2] ^ w_m9[3],
                    w_m9[0]  ^ w_m14[1] ^ w_m11[2] ^ w_m13[3],
                    w_m13[0] ^ w_m9[1]  ^ w_m14[2] ^ w_m11[3],
                    w_m11[0] ^ w_m13[1] ^ w_m9[2]  ^ w_m14[3]};

endmodule

// File: rtl/imix_col_sequencer.sv
// Iterative InvMixColumns: time-shares COLS_PER_CYC column units over the 4 state columns,
// with a per-block bypass for rounds without InvMixColumns.
module imix_col_sequencer
    import aes_dec_pkg::*;
#(
    parameter int unsigned COLS_PER_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int unsigned NGRP  = AES_NCOL / COLS_PER_CYC;
    localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cols
        $error("imix_col_sequencer: COLS_PER_CYC must be 1, 2 or 4");
    end

    imix_state_e            r_state;
    imix_state_e            w_state_nxt;
    logic [GRP_W-1:0]       r_grp_cnt;
    logic [AES_STATE_W-1:0] r_data_q;
    logic [AES_STATE_W-1:0] w_data_mix;
    logic                   w_in_fire;
    logic                   w_grp_last;
    logic [1:0]             w_col_idx [COLS_PER_CYC];
    logic [AES_COL_W-1:0]   w_col_in  [COLS_PER_CYC];
    logic [AES_COL_W-1:0]   w_col_out [COLS_PER_CYC];

    assign w_in_fire  = in_valid && (r_state == IDLE);
    assign w_grp_last = (r_grp_cnt == GRP_W'(NGRP - 1));

    for (genvar k = 0; k < COLS_PER_CYC; k++) begin : g_col
        assign w_col_idx[k] = 2'(32'(r_grp_cnt) * COLS_PER_CYC + 32'(k));
        assign w_col_in[k]  = col_sel(r_data_q, w_col_idx[k]);

        imix_single_col u_col (
            .i_col (w_col_in[k]),
            .o_col (w_col_out[k])
        );
    end

    // Replace only the columns of the current group; the rest hold.
    always_comb begin
        w_data_mix = r_data_q;
        for (int unsigned k = 0; k < COLS_PER_CYC; k++) begin
            w_data_mix[AES_STATE_W - 1 - AES_COL_W * 32'(w_col_idx[k]) -: AES_COL_W] = w_col_out[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = in_bypass ? DONE : RUN;
            RUN:     if (w_grp_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q  <= '0;
            r_grp_cnt <= '0;
        end else if (w_in_fire) begin
            r_data_q  <= in_data;
            r_grp_cnt <= '0;
        end else if (r_state == RUN) begin
            r_data_q  <= w_data_mix;
            r_grp_cnt <= w_grp_last ? '0 : r_grp_cnt + GRP_W'(1);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign out_data  = r_data_q;

endmodule
